// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer.
// Holds the default datapath widths and the FSM state encoding.
package mul_sequencer_pkg;

   localparam int unsigned REGISTER_WIDTH = 8;
   localparam int unsigned REG_ADDR_WIDTH = 3;
   localparam int unsigned COUNT_WIDTH    = 4;

   typedef enum logic [1:0] {
      MUL_IDLE  = 2'd0,
      MUL_RUN   = 2'd1,
      MUL_WRITE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/mul_shift_add_step.sv
// One iteration of the shift-add multiply: conditionally add the multiplicand
// into the accumulator, then shift {acc, mplier} right by one.
// Ports:
//   acc_i      accumulator (one extra bit keeps the adder carry)
//   mplier_i   multiplier / low product bits
//   mcand_i    multiplicand
//   acc_o      next accumulator
//   mplier_o   next multiplier / low product bits
module mul_shift_add_step #(
   parameter int unsigned Width = 8
) (
   input  logic [Width:0]   acc_i,
   input  logic [Width-1:0] mplier_i,
   input  logic [Width-1:0] mcand_i,
   output logic [Width:0]   acc_o,
   output logic [Width-1:0] mplier_o
);

   logic [Width:0]   sum;
   logic [Width-1:0] addend;

   always_comb begin
      addend = mcand_i & {Width{mplier_i[0]}};
      // acc_i never exceeds Width significant bits, so the sum fits in Width+1.
      sum      = acc_i + {1'b0, addend};
      acc_o    = {1'b0, sum[Width:1]};
      mplier_o = {sum[0], mplier_i[Width-1:1]};
   end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiply controller for the register-file datapath.
// Latches a MUL request, stalls the PC for REGISTER_WIDTH iterations, then
// issues a one-cycle register write of the low product half.
// Ports:
//   clock, isResetN          clock and synchronous active-low reset
//   start                    decoded MUL valid (level, held while stalled)
//   operandA/operandB        multiplicand / multiplier
//   destReg                  destination register index
//   stall, busy              PC hold and not-idle indication
//   writeEnable, writeReg,
//   writeValue               register write request (suppressed for reg 0)
//   overflow                 high product half nonzero, valid with done
//   done                     one-cycle completion pulse
module mul_sequencer #(
   parameter int unsigned REGISTER_WIDTH = mul_sequencer_pkg::REGISTER_WIDTH,
   parameter int unsigned REG_ADDR_WIDTH = mul_sequencer_pkg::REG_ADDR_WIDTH,
   parameter int unsigned COUNT_WIDTH    = mul_sequencer_pkg::COUNT_WIDTH
) (
   input  logic                      clock,
   input  logic                      isResetN,
   input  logic                      start,
   input  logic [REGISTER_WIDTH-1:0] operandA,
   input  logic [REGISTER_WIDTH-1:0] operandB,
   input  logic [REG_ADDR_WIDTH-1:0] destReg,
   output logic                      stall,
   output logic                      busy,
   output logic                      writeEnable,
   output logic [REG_ADDR_WIDTH-1:0] writeReg,
   output logic [REGISTER_WIDTH-1:0] writeValue,
   output logic                      overflow,
   output logic                      done
);
   import mul_sequencer_pkg::*;

   mul_state_e                state_q, state_d;
   logic [COUNT_WIDTH-1:0]    counter_q, counter_d;
   logic [REGISTER_WIDTH-1:0] mcand_q, mcand_d;
   logic [REGISTER_WIDTH-1:0] mplier_q, mplier_d;
   logic [REGISTER_WIDTH:0]   acc_q, acc_d;
   logic [REG_ADDR_WIDTH-1:0] dreg_q, dreg_d;

   logic [REGISTER_WIDTH:0]   step_acc;
   logic [REGISTER_WIDTH-1:0] step_mplier;

   mul_shift_add_step #(
      .Width(REGISTER_WIDTH)
   ) u_step (
      .acc_i    (acc_q),
      .mplier_i (mplier_q),
      .mcand_i  (mcand_q),
      .acc_o    (step_acc),
      .mplier_o (step_mplier)
   );

   always_comb begin
      state_d     = state_q;
      counter_d   = counter_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      dreg_d      = dreg_q;
      stall       = 1'b0;
      done        = 1'b0;
      writeEnable = 1'b0;

      unique case (state_q)
         MUL_IDLE: begin
            if (start) begin
               // Stall on the issue edge itself so the PC holds the MUL.
               stall     = 1'b1;
               mcand_d   = operandA;
               mplier_d  = operandB;
               dreg_d    = destReg;
               acc_d     = '0;
               counter_d = '0;
               state_d   = MUL_RUN;
            end
         end
         MUL_RUN: begin
            stall     = 1'b1;
            acc_d     = step_acc;
            mplier_d  = step_mplier;
            counter_d = counter_q + COUNT_WIDTH'(1);
            if (counter_q == COUNT_WIDTH'(REGISTER_WIDTH - 1)) begin
               state_d = MUL_WRITE;
            end
         end
         MUL_WRITE: begin
            done        = 1'b1;
            // Register 0 is hard-wired to zero: complete without writing.
            writeEnable = (dreg_q != '0);
            state_d     = MUL_IDLE;
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!isResetN) begin
         state_q   <= MUL_IDLE;
         counter_q <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         dreg_q    <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         dreg_q    <= dreg_d;
      end
   end

   assign busy       = (state_q != MUL_IDLE);
   assign writeValue = mplier_q;
   assign writeReg   = dreg_q;
   assign overflow   = |acc_q[REGISTER_WIDTH-1:0];

endmodule
